// File: rtl/max_stream_reduce.sv
// ---------------------------------------------------------------------------
// max_stream_reduce
//
// Finds the maximum of a framed sample stream. The block returns the maximum
// value, the 0-based position of its first occurrence, and the number of
// samples in the frame.
//
// A frame closes on the sample that brings the count to FRAME, or earlier on
// a sample flagged with in_last. The result is then held until downstream
// accepts it. The output registers keep their last result after the
// transfer, until the next frame closes.
//
// Parameters
//   WIDTH   operand width in bits
//   FRAME   maximum samples per frame (2..256)
//   SIGNED  0 = unsigned compare, 1 = two's-complement compare
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream sample valid
//   in_ready   block accepts a sample this cycle
//   in_data    sample operand
//   in_last    accompanying sample closes the frame early
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_max    frame maximum
//   out_idx    position of the maximum within the frame
//   out_cnt    number of samples in the frame
// ---------------------------------------------------------------------------
module max_stream_reduce #(
  parameter  int WIDTH  = 8,
  parameter  int FRAME  = 8,
  parameter  int SIGNED = 0,
  localparam int IDXW   = $clog2(FRAME),
  localparam int CNTW   = $clog2(FRAME + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDXW-1:0]  out_idx,
  output logic [CNTW-1:0]  out_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           state_q, state_d;

  // Running accumulator for the frame in progress.
  logic [WIDTH-1:0] max_q, max_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  // Result registers. These are kept apart from the accumulator so that the
  // outputs stay stable while the next frame is building up.
  logic [WIDTH-1:0] res_max_q, res_max_d;
  logic [IDXW-1:0]  res_idx_q, res_idx_d;
  logic [CNTW-1:0]  res_cnt_q, res_cnt_d;

  logic             accept;
  logic             greater;
  logic [CNTW-1:0]  cnt_inc;
  logic             close_frame;

  // in_ready depends only on the registered state and the reset, so there is
  // no path from out_ready. Gating with rst_n holds it low during reset and
  // raises it as soon as reset is released.
  assign in_ready  = rst_n && (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;

  assign out_max = res_max_q;
  assign out_idx = res_idx_q;
  assign out_cnt = res_cnt_q;

  // Strict comparison: an equal value never wins, so ties keep the earliest
  // index.
  always_comb begin
    if (SIGNED != 0) begin
      greater = $signed(in_data) > $signed(max_q);
    end else begin
      greater = in_data > max_q;
    end
  end

  assign cnt_inc     = cnt_q + CNTW'(1);
  assign close_frame = (cnt_inc == CNTW'(FRAME)) || in_last;

  // Next-state and datapath logic.
  // While accumulating, cnt_q never exceeds FRAME-1. It therefore always
  // fits in IDXW bits when it is used as the index of a new maximum.
  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    res_max_d = res_max_q;
    res_idx_d = res_idx_q;
    res_cnt_d = res_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          max_d = in_data;
          idx_d = '0;
          cnt_d = CNTW'(1);
          if (in_last) begin
            state_d   = HOLD;
            res_max_d = in_data;
            res_idx_d = '0;
            res_cnt_d = CNTW'(1);
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (greater) begin
            max_d = in_data;
            idx_d = cnt_q[IDXW-1:0];
          end
          if (close_frame) begin
            state_d   = HOLD;
            res_max_d = max_d;
            res_idx_d = idx_d;
            res_cnt_d = cnt_inc;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator and result registers. Reset discards any partial
  // frame or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      max_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      res_max_q <= '0;
      res_idx_q <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      res_max_q <= res_max_d;
      res_idx_q <= res_idx_d;
      res_cnt_q <= res_cnt_d;
    end
  end

endmodule

// File: tb/tb_max_stream_reduce.sv
// ---------------------------------------------------------------------------
// tb_max_stream_reduce
//
// Drives one stimulus stream into two instances of max_stream_reduce.
// Both use WIDTH=8 and FRAME=4; one compares unsigned and the other signed.
// Expected results are queued when a frame's closing sample is driven. They
// are popped and compared when the result appears.
// ---------------------------------------------------------------------------
module tb_max_stream_reduce;

  typedef struct packed {
    logic [7:0] mx;
    logic [1:0] idx;
    logic [2:0] cnt;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_u, out_valid_u;
  logic [7:0] out_max_u;
  logic [1:0] out_idx_u;
  logic [2:0] out_cnt_u;

  logic       in_ready_s, out_valid_s;
  logic [7:0] out_max_s;
  logic [1:0] out_idx_s;
  logic [2:0] out_cnt_s;

  res_t qU[$];
  res_t qS[$];
  res_t lastU, lastS;

  int nAsserts = 0;
  int nFail    = 0;
  int accCnt   = 0;
  int xferCnt  = 0;

  max_stream_reduce #(.WIDTH(8), .FRAME(4), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .out_max(out_max_u), .out_idx(out_idx_u), .out_cnt(out_cnt_u)
  );

  max_stream_reduce #(.WIDTH(8), .FRAME(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_max(out_max_s), .out_idx(out_idx_s), .out_cnt(out_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes on the unsigned instance.
  always @(posedge clk) begin
    if (in_valid && in_ready_u) accCnt++;
    if (out_valid_u && out_ready) xferCnt++;
  end

  // Bound the whole run so the bench always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expectResult(input res_t u, input res_t s);
    qU.push_back(u);
    qS.push_back(s);
  endtask

  // Present one sample and hold it until accepted, or until the bound runs out.
  task automatic applyStimulus(input logic [7:0] d, input bit last);
    bit accepted = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (in_ready_u) accepted = 1'b1;
      @(posedge clk);
      if (!accepted) @(negedge clk);
    end
    checkEq("accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic idleCycle(input bit last);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = last;
    in_data  = 8'($urandom);
  endtask

  // Called right after the closing accept: the result must be visible one
  // cycle later, with in_ready low.
  task automatic checkOutput(input bit keepValid);
    res_t eu, es;
    @(negedge clk);
    if (!keepValid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    checkEq("out_valid_u", {31'd0, out_valid_u}, 32'd1);
    checkEq("out_valid_s", {31'd0, out_valid_s}, 32'd1);
    checkEq("in_ready_hold", {31'd0, in_ready_u}, 32'd0);
    checkEq("sb_depth_u", qU.size(), 32'd1);
    checkEq("sb_depth_s", qS.size(), 32'd1);
    if (qU.size() > 0 && qS.size() > 0) begin
      eu = qU.pop_front();
      es = qS.pop_front();
      checkEq("max_u", {24'd0, out_max_u}, {24'd0, eu.mx});
      checkEq("idx_u", {30'd0, out_idx_u}, {30'd0, eu.idx});
      checkEq("cnt_u", {29'd0, out_cnt_u}, {29'd0, eu.cnt});
      checkEq("max_s", {24'd0, out_max_s}, {24'd0, es.mx});
      checkEq("idx_s", {30'd0, out_idx_s}, {30'd0, es.idx});
      checkEq("cnt_s", {29'd0, out_cnt_s}, {29'd0, es.cnt});
      lastU = eu;
      lastS = es;
    end
  endtask

  // After a transfer: valid drops, ready rises, and the result is retained.
  task automatic drainCheck();
    @(negedge clk);
    checkEq("drain_valid", {31'd0, out_valid_u}, 32'd0);
    checkEq("drain_ready", {31'd0, in_ready_u}, 32'd1);
    checkEq("retain_max_u", {24'd0, out_max_u}, {24'd0, lastU.mx});
    checkEq("retain_cnt_s", {29'd0, out_cnt_s}, {29'd0, lastS.cnt});
  endtask

  initial begin
    int acc0, xfer0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset values, checked without relying on clock edges.
    #23;
    checkEq("rst_in_ready", {31'd0, in_ready_u}, 32'd0);
    checkEq("rst_out_valid", {31'd0, out_valid_s}, 32'd0);
    checkEq("rst_max", {24'd0, out_max_u}, 32'd0);
    checkEq("rst_idx", {30'd0, out_idx_u}, 32'd0);
    checkEq("rst_cnt", {29'd0, out_cnt_u}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkEq("post_rst_ready", {31'd0, in_ready_u}, 32'd1);

    // Full frame with a tie on 9: the earliest index must win.
    applyStimulus(8'd3, 1'b0);
    applyStimulus(8'd9, 1'b0);
    applyStimulus(8'd9, 1'b0);
    expectResult('{8'd9, 2'd1, 3'd4}, '{8'd9, 2'd1, 3'd4});
    applyStimulus(8'd2, 1'b0);
    checkOutput(1'b0);
    drainCheck();

    // Early close via in_last.
    applyStimulus(8'd5, 1'b0);
    expectResult('{8'd7, 2'd1, 3'd2}, '{8'd7, 2'd1, 3'd2});
    applyStimulus(8'd7, 1'b1);
    checkOutput(1'b0);
    drainCheck();

    // Backpressure: hold the result for 10 cycles while in_valid stays high.
    out_ready = 1'b0;
    applyStimulus(8'd10, 1'b0);
    applyStimulus(8'd20, 1'b0);
    applyStimulus(8'd30, 1'b0);
    expectResult('{8'd40, 2'd3, 3'd4}, '{8'd40, 2'd3, 3'd4});
    applyStimulus(8'd40, 1'b0);
    checkOutput(1'b1);
    in_data = 8'hAA;
    acc0  = accCnt;
    xfer0 = xferCnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkEq("stall_valid", {31'd0, out_valid_u}, 32'd1);
      checkEq("stall_max", {24'd0, out_max_u}, 32'd40);
      checkEq("stall_ready", {31'd0, in_ready_u}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkEq("bp_valid_drop", {31'd0, out_valid_u}, 32'd0);
    checkEq("bp_ready_rise", {31'd0, in_ready_u}, 32'd1);
    checkEq("bp_no_accept", accCnt, acc0);
    checkEq("bp_one_xfer", xferCnt, xfer0 + 1);

    // Signed versus unsigned compare. A stray in_last without in_valid must
    // be ignored mid-frame.
    applyStimulus(8'h80, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    idleCycle(1'b1);
    applyStimulus(8'h01, 1'b0);
    expectResult('{8'hFF, 2'd1, 3'd4}, '{8'h7F, 2'd3, 3'd4});
    applyStimulus(8'h7F, 1'b0);
    checkOutput(1'b0);
    drainCheck();

    // Reset mid-frame discards the partial frame.
    applyStimulus(8'h50, 1'b0);
    applyStimulus(8'h60, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    xfer0    = xferCnt;
    rst_n    = 1'b0;
    #1;
    checkEq("mid_rst_ready", {31'd0, in_ready_s}, 32'd0);
    checkEq("mid_rst_cnt", {29'd0, out_cnt_u}, 32'd0);
    checkEq("mid_rst_max", {24'd0, out_max_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd1, 1'b0);
    checkEq("no_stale_xfer", xferCnt, xfer0);
    expectResult('{8'd1, 2'd0, 3'd4}, '{8'd1, 2'd0, 3'd4});
    applyStimulus(8'd1, 1'b0);
    checkOutput(1'b0);
    drainCheck();

    // Single-sample frame from IDLE.
    expectResult('{8'h42, 2'd0, 3'd1}, '{8'h42, 2'd0, 3'd1});
    applyStimulus(8'h42, 1'b1);
    checkOutput(1'b0);
    drainCheck();

    // Totals: 6 results, 21 accepted samples (including 2 discarded by reset).
    repeat (2) @(negedge clk);
    checkEq("total_xfer", xferCnt, 32'd6);
    checkEq("total_accept", accCnt, 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
